// File: rtl/spi_arbiter.sv
// rtl/spi_arbiter.sv - round-robin arbiter/sequencer sharing one spi master between NUM_REQ requesters
module spi_arbiter #(
  parameter int DATA_BITS = 8,
  parameter int NUM_REQ   = 4,
  parameter int TIMEOUT   = 1024
) (
  input  logic                         clk,
  input  logic                         n_rst,
  input  logic [NUM_REQ-1:0]           req,
  input  logic [NUM_REQ*DATA_BITS-1:0] req_data,
  output logic [NUM_REQ-1:0]           gnt,
  output logic [NUM_REQ-1:0]           rsp_valid,
  output logic [DATA_BITS-1:0]         rsp_data,
  output logic                         rsp_err,
  output logic                         busy,
  output logic                         spi_enable,
  output logic [DATA_BITS-1:0]         spi_wdata,
  input  logic                         spi_ready,
  input  logic                         spi_valid,
  input  logic [DATA_BITS-1:0]         spi_rdata
);

  localparam int PW = $clog2(NUM_REQ);
  localparam int CW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {ST_IDLE, ST_LAUNCH, ST_WAIT} state_t;

  state_t          state;
  logic [PW-1:0]   ptr;
  logic [PW-1:0]   owner;
  logic [CW-1:0]   cnt;

  logic            win_found;
  logic [PW-1:0]   win_idx;
  logic [PW-1:0]   ptr_next;
  logic [PW:0]     cand;

  // Scan ptr, ptr+1, ... with wrap; one extra bit keeps ptr+i from overflowing.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = {1'b0, ptr} + (PW+1)'(i);
      if (cand >= (PW+1)'(NUM_REQ))
        cand = cand - (PW+1)'(NUM_REQ);
      if (!win_found && req[cand[PW-1:0]]) begin
        win_found = 1'b1;
        win_idx   = cand[PW-1:0];
      end
    end
  end

  always_comb begin
    ptr_next = '0;
    if (win_idx != PW'(NUM_REQ - 1))
      ptr_next = win_idx + 1'b1;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state      <= ST_IDLE;
      ptr        <= '0;
      owner      <= '0;
      cnt        <= '0;
      gnt        <= '0;
      rsp_valid  <= '0;
      rsp_data   <= '0;
      rsp_err    <= 1'b0;
      busy       <= 1'b0;
      spi_enable <= 1'b0;
      spi_wdata  <= '0;
    end else begin
      gnt        <= '0;
      rsp_valid  <= '0;
      spi_enable <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (win_found && spi_ready) begin
            state      <= ST_LAUNCH;
            owner      <= win_idx;
            ptr        <= ptr_next;
            spi_wdata  <= req_data[win_idx*DATA_BITS +: DATA_BITS];
            gnt        <= {{(NUM_REQ-1){1'b0}}, 1'b1} << win_idx;
            spi_enable <= 1'b1;
            busy       <= 1'b1;
          end
        end
        ST_LAUNCH: begin
          state <= ST_WAIT;
          cnt   <= '0;
        end
        ST_WAIT: begin
          // A completion in the final watchdog cycle still counts as success.
          if (spi_valid) begin
            state     <= ST_IDLE;
            rsp_data  <= spi_rdata;
            rsp_err   <= 1'b0;
            rsp_valid <= {{(NUM_REQ-1){1'b0}}, 1'b1} << owner;
            busy      <= 1'b0;
          end else if (cnt == CW'(TIMEOUT - 1)) begin
            state     <= ST_IDLE;
            rsp_data  <= '0;
            rsp_err   <= 1'b1;
            rsp_valid <= {{(NUM_REQ-1){1'b0}}, 1'b1} << owner;
            busy      <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_arbiter.sv
// tb/tb_spi_arbiter.sv - directed self-checking bench for spi_arbiter with a stub spi master
module tb_spi_arbiter;

  logic        clk = 1'b0;
  logic        n_rst;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic [3:0]  gnt;
  logic [3:0]  rsp_valid;
  logic [7:0]  rsp_data;
  logic        rsp_err;
  logic        busy;
  logic        spi_enable;
  logic [7:0]  spi_wdata;
  logic        spi_ready;
  logic        spi_valid;
  logic [7:0]  spi_rdata;

  int checks = 0;
  int errors = 0;

  spi_arbiter #(.DATA_BITS(8), .NUM_REQ(4), .TIMEOUT(16)) dut (
    .clk        (clk),
    .n_rst      (n_rst),
    .req        (req),
    .req_data   (req_data),
    .gnt        (gnt),
    .rsp_valid  (rsp_valid),
    .rsp_data   (rsp_data),
    .rsp_err    (rsp_err),
    .busy       (busy),
    .spi_enable (spi_enable),
    .spi_wdata  (spi_wdata),
    .spi_ready  (spi_ready),
    .spi_valid  (spi_valid),
    .spi_rdata  (spi_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic check_quiet(input string tag);
    chk({tag, "_gnt"}, gnt, 0);
    chk({tag, "_rspv"}, rsp_valid, 0);
    chk({tag, "_rspd"}, rsp_data, 0);
    chk({tag, "_rspe"}, rsp_err, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_en"}, spi_enable, 0);
    chk({tag, "_wd"}, spi_wdata, 0);
  endtask

  task automatic apply_reset(input string tag);
    n_rst = 1'b0; req = '0; spi_valid = 1'b0; spi_ready = 1'b1; spi_rdata = '0;
    tick; tick;
    check_quiet(tag);
    n_rst = 1'b1;
    tick;
  endtask

  // Expects LAUNCH in the cycle right after the current negedge; stub master then drops ready.
  task automatic wait_launch(input string tag, input logic [3:0] exp_gnt, input logic [7:0] exp_wd);
    int n = 0;
    tick;
    while (!spi_enable && n < 50) begin
      tick;
      n++;
    end
    chk({tag, "_lat"}, n, 0);
    chk({tag, "_gnt"}, gnt, exp_gnt);
    chk({tag, "_wd"}, spi_wdata, exp_wd);
    chk({tag, "_busy"}, busy, 1);
    spi_ready = 1'b0;
  endtask

  task automatic respond(input string tag, input logic [3:0] exp_rv, input logic [7:0] d, input int lat);
    repeat (lat) tick;
    spi_valid = 1'b1;
    spi_rdata = d;
    tick;
    spi_valid = 1'b0;
    chk({tag, "_rspv"}, rsp_valid, exp_rv);
    chk({tag, "_rspd"}, rsp_data, d);
    chk({tag, "_rspe"}, rsp_err, 0);
    chk({tag, "_gnt0"}, gnt, 0);
    chk({tag, "_busy0"}, busy, 0);
    spi_ready = 1'b1;
  endtask

  initial begin
    int order [6] = '{0, 1, 3, 0, 1, 3};
    logic [3:0] seen;
    int n;

    apply_reset("rst");

    // single requester
    req_data = 32'h000000AA;
    req = 4'b0001;
    wait_launch("single", 4'b0001, 8'hAA);
    req = '0;
    respond("single", 4'b0001, 8'hCC, 3);

    // fairness from reset with req 0,1,3 held
    apply_reset("rst2");
    req_data = 32'hD3C2B1A0;
    req = 4'b1011;
    for (int k = 0; k < 6; k++) begin
      logic [31:0] rd;
      rd = req_data >> (order[k] * 8);
      wait_launch($sformatf("fair%0d", k), 4'b0001 << order[k], rd[7:0]);
      respond($sformatf("fair%0d", k), 4'b0001 << order[k], 8'h50 + 8'(k), 2);
    end
    req = '0;
    tick;

    // ready gating
    spi_ready = 1'b0;
    req = 4'b0100;
    seen = '0;
    repeat (20) begin
      tick;
      seen = seen | gnt;
    end
    chk("gate_nognt", seen, 0);
    spi_ready = 1'b1;
    wait_launch("gate", 4'b0100, 8'hC2);
    req = '0;
    respond("gate", 4'b0100, 8'h81, 1);

    // timeout: ptr is 3, req[1] wins
    req = 4'b0010;
    spi_rdata = 8'h77;
    wait_launch("tmo", 4'b0010, 8'hB1);
    req = '0;
    n = 0;
    do begin
      tick;
      n++;
    end while (rsp_valid == 0 && n < 40);
    chk("tmo_cycles", n, 17);
    chk("tmo_rspv", rsp_valid, 4'b0010);
    chk("tmo_err", rsp_err, 1);
    chk("tmo_data", rsp_data, 0);
    spi_ready = 1'b1;

    // normal grant after timeout: ptr is 2, req[0] wins
    req = 4'b0001;
    wait_launch("post_tmo", 4'b0001, 8'hA0);
    req = '0;
    respond("post_tmo", 4'b0001, 8'h3C, 4);

    // spi_valid in IDLE ignored
    spi_valid = 1'b1;
    spi_rdata = 8'h99;
    tick;
    spi_valid = 1'b0;
    tick;
    chk("idle_valid_rspv", rsp_valid, 0);
    chk("idle_valid_busy", busy, 0);

    // spi_valid on the final watchdog cycle: ptr is 1, req[3] wins
    req = 4'b1000;
    wait_launch("edge", 4'b1000, 8'hD3);
    req = '0;
    respond("edge", 4'b1000, 8'hE1, 16);

    // reset mid-WAIT: ptr is 0, req[2] wins
    req = 4'b0100;
    wait_launch("mid", 4'b0100, 8'hC2);
    req = '0;
    repeat (3) tick;
    #2 n_rst = 1'b0;
    #1 check_quiet("midrst");
    tick;
    n_rst = 1'b1;
    spi_ready = 1'b1;
    seen = '0;
    repeat (20) begin
      tick;
      seen = seen | rsp_valid;
    end
    chk("midrst_norsp", seen, 0);
    req = 4'b1010;
    wait_launch("after_rst", 4'b0010, 8'hB1);
    req = '0;
    respond("after_rst", 4'b0010, 8'h5A, 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
